// File: rtl/instr_fetch.sv
// Instruction fetch: requests words from instruction memory,
// steers the PC and buffers fetched words in a 2-deep FIFO.
module instr_fetch #(
    parameter int n = 4,
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [n-1:0] pcIn,
    output logic [1:0]   pcCntrl,
    output logic [n-1:0] pcLoad,
    output logic         memReq,
    output logic [n-1:0] memAddr,
    input  logic         memAck,
    input  logic [w-1:0] memData,
    output logic [w-1:0] instr,
    output logic         instrValid,
    input  logic         instrReady,
    input  logic         flush,
    input  logic [n-1:0] flushAddr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_LOAD = 2'b01;
    localparam logic [1:0] PC_INC  = 2'b10;

    state_t         state;
    state_t         state_nx;
    logic [1:0]     cnt;
    logic [1:0]     cnt_nx;
    logic           rp;
    logic           wp;
    logic [w-1:0]   mem [2];
    logic           push;
    logic           pop;

    // Push/pop qualification, next count and next FSM state.
    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        cnt_nx   = cnt;
        state_nx = state;
        if (clr && !flush) begin
            push = (state == REQ) && memAck;
            pop  = (cnt != 2'd0) && instrReady;
        end
        cnt_nx = cnt + {1'b0, push} - {1'b0, pop};
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: state_nx = (cnt < 2'd2) ? REQ : WAIT;
                REQ: begin
                    if (push)
                        state_nx = (cnt_nx < 2'd2) ? REQ : WAIT;
                end
                WAIT: state_nx = (cnt_nx < 2'd2) ? REQ : WAIT;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Externally visible outputs; everything is forced low in reset.
    always_comb begin
        pcCntrl    = PC_HOLD;
        pcLoad     = '0;
        memReq     = 1'b0;
        memAddr    = '0;
        instr      = '0;
        instrValid = 1'b0;
        if (clr) begin
            if (flush) begin
                pcCntrl = PC_LOAD;
                pcLoad  = flushAddr;
            end else if (push) begin
                pcCntrl = PC_INC;
            end
            if (state == REQ) begin
                memReq  = 1'b1;
                memAddr = pcIn;
            end
            if (cnt != 2'd0) begin
                instrValid = 1'b1;
                instr      = mem[rp];
            end
        end
    end

    // FSM state, FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            rp     <= 1'b0;
            wp     <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                cnt <= 2'd0;
                rp  <= 1'b0;
                wp  <= 1'b0;
            end else begin
                cnt <= cnt_nx;
                if (push) begin
                    mem[wp] <= memData;
                    wp      <= ~wp;
                end
                if (pop)
                    rp <= ~rp;
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter n SHALL default to 4 and set the instruction-address width, matching the program counter width.
REQ-002 Parameter w SHALL default to 8 and set the instruction width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 clr  input  1  SHALL be a synchronous, active-low reset sampled on rising clk.
REQ-005 pcIn  input  n  SHALL carry the current program-counter value.
REQ-006 pcCntrl  output  2  SHALL be the PC control code: 00 hold, 01 load, 10 increment; 11 is never driven.
REQ-007 pcLoad  output  n  SHALL be the PC load value, meaningful only when pcCntrl=01.
REQ-008 memReq  output  1  SHALL be the instruction-memory read request.
REQ-009 memAddr  output  n  SHALL be the read address.
REQ-010 memAck  input  1  SHALL indicate that memData is valid this cycle for the outstanding request.
REQ-011 memData  input  w  SHALL carry the instruction word returned by memory.
REQ-012 instr  output  w  SHALL carry the head instruction to decode.
REQ-013 instrValid  output  1  SHALL indicate that instr is valid.
REQ-014 instrReady  input  1  SHALL indicate that decode accepts instr this cycle.
REQ-015 flush  input  1  SHALL be the redirect request from branch resolution.
REQ-016 flushAddr  input  n  SHALL be the redirect target.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, REQ and WAIT.
REQ-018 The block SHALL buffer instructions in a 2-entry FIFO of w-bit words with a count of 0..2.
REQ-019 In IDLE, the FSM SHALL move to REQ on the next edge if count<2, else to WAIT.
REQ-020 In REQ, memReq SHALL be 1 and memAddr SHALL equal pcIn; in IDLE and WAIT, memReq SHALL be 0 and memAddr SHALL be 0.
REQ-021 In REQ, memReq SHALL stay asserted and pcIn SHALL stay unchanged (pcCntrl=00) until memAck.
REQ-022 On memAck in REQ without flush, the block SHALL push memData, drive pcCntrl=10 that same cycle, and stay in REQ if the post-update count is <2, else go to WAIT.
REQ-023 A push SHALL complete in 1 cycle: data acked in cycle t SHALL appear on instr with instrValid=1 in cycle t+1 when the FIFO was empty.
REQ-024 The FSM SHALL leave WAIT for REQ on the edge at which count drops below 2.
REQ-025 instrValid SHALL equal (count!=0), and instr SHALL be the oldest entry (0 when empty).
REQ-026 A pop SHALL occur when instrValid and instrReady are both 1; instrReady with count=0 SHALL have no effect.
REQ-027 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-028 Count SHALL never exceed 2; REQ is unreachable with count=2.
REQ-029 flush SHALL have priority over push, pop and memAck.
REQ-030 On flush, the FIFO SHALL be emptied on the next edge.
REQ-031 On flush, pcCntrl SHALL be 01 and pcLoad SHALL equal flushAddr in the same cycle.
REQ-032 On flush, the FSM SHALL go to IDLE on the next edge.
REQ-033 A memAck coinciding with flush SHALL be discarded.
REQ-034 A memAck arriving outside REQ SHALL be ignored.
REQ-035 pcCntrl SHALL be 00 in every cycle without an accepted memAck or a flush.
REQ-036 pcLoad SHALL be 0 when pcCntrl is not 01.
REQ-037 FIFO read and write pointers SHALL be 1 bit each and wrap modulo 2.

Reset
REQ-038 When clr=0 at a rising edge, the FSM SHALL go to IDLE and count, both pointers and all FIFO entries SHALL clear to 0.
REQ-039 During the clr=0 cycle and the cycle after it, memReq, memAddr, pcCntrl, pcLoad, instrValid and instr SHALL all be 0.
REQ-040 clr=0 SHALL take precedence over flush, memAck and instrReady.
REQ-041 A reset during an outstanding request SHALL abandon that request, and a memAck on the reset cycle SHALL be discarded.

Verification
REQ-042 Streaming: clr released, memAck tied 1, instrReady tied 1, pcIn following pcCntrl from 0 -> memAddr 0,1,2,... on consecutive REQ cycles; pcCntrl=10 each acked cycle; instr sequence matches memData with 1-cycle latency.
REQ-043 Backpressure: instrReady=0, memAck=1, memData=8'hA1 then 8'hB2 -> count reaches 2, FSM in WAIT, memReq=0; instrReady=1 for one cycle -> pop of A1, then REQ re-entered next edge.
REQ-044 Slow memory: memAck held 0 for 3 cycles in REQ -> memReq=1, memAddr stable, pcCntrl=00 throughout; ack on 4th cycle -> single push, single pcCntrl=10.
REQ-045 Flush with ack: count=1, flush=1 with flushAddr=4'hC and memAck=1 in the same cycle -> pcCntrl=01, pcLoad=C, memData discarded, instrValid=0 next cycle, IDLE next cycle.
REQ-046 Full push/pop: count=1, memAck=1 and instrReady=1 together -> count stays 1, head becomes the new word, FSM stays REQ.
REQ-047 Mid-request reset: clr=0 while memReq=1 and memAck=1 -> all outputs 0 next cycle, count=0, no push.
